// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer: accepts one instruction at a time, decodes it into control strobes
// and steps it across VLEN/LANES beats (one beat for scalar), stalling memory beats on mem_ready_i.
module vector_issue_sequencer #(
    parameter int VLEN  = 16,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic [1:0]               op_i,
    input  logic [1:0]               inst_i,
    input  logic                     flagv_i,
    input  logic                     mem_ready_i,
    output logic                     wmem_o,
    output logic                     rmem_o,
    output logic                     wreg_o,
    output logic                     cond_en_o,
    output logic                     jmp_sel_o,
    output logic                     vf_o,
    output logic [1:0]               jmp_f_o,
    output logic [1:0]               rmux_sel_o,
    output logic [2:0]               alu_ins_o,
    output logic [1:0]               extnd_sel_o,
    output logic [$clog2(VLEN)-1:0]  lane_base_o,
    output logic [LANES-1:0]         lane_mask_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int BEATS = VLEN / LANES;
    localparam int IW    = $clog2(VLEN);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [1:0]    op_q, op_d, inst_q, inst_d;
    logic          flagv_q, flagv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            op_q    <= '0;
            inst_q  <= '0;
            flagv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            op_q    <= op_d;
            inst_q  <= inst_d;
            flagv_q <= flagv_d;
        end
    end

    logic jmp, jeq, stl, str, cmpr, cmpi, add, sub, mul, div, ldr, movr, movi;
    assign jmp  = op_q == 2'b00 && inst_q == 2'b00;
    assign jeq  = op_q == 2'b00 && inst_q == 2'b01;
    assign stl  = op_q == 2'b00 && inst_q == 2'b10;
    assign str  = op_q == 2'b01 && inst_q == 2'b00;
    assign cmpr = op_q == 2'b01 && inst_q == 2'b01;
    assign cmpi = op_q == 2'b01 && inst_q == 2'b10;
    assign add  = op_q == 2'b10 && inst_q == 2'b00;
    assign sub  = op_q == 2'b10 && inst_q == 2'b01;
    assign mul  = op_q == 2'b10 && inst_q == 2'b10;
    assign div  = op_q == 2'b10 && inst_q == 2'b11;
    assign ldr  = op_q == 2'b11 && inst_q == 2'b01;
    assign movr = op_q == 2'b11 && inst_q == 2'b10;
    assign movi = op_q == 2'b11 && inst_q == 2'b11;

    logic exec, is_mem, is_vec, last, adv;
    assign exec   = state_q == S_EXEC;
    assign is_mem = str | ldr;
    assign is_vec = flagv_q & (is_mem | add | sub | mul | div);
    assign last   = !is_vec || beat_q == BW'(BEATS - 1);
    // memory beats hold until the memory side acknowledges
    assign adv    = exec && (!is_mem || mem_ready_i);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        op_d    = op_q;
        inst_d  = inst_q;
        flagv_d = flagv_q;
        case (state_q)
            S_IDLE: if (instr_valid_i) begin
                state_d = S_EXEC;
                beat_d  = '0;
                op_d    = op_i;
                inst_d  = inst_i;
                flagv_d = flagv_i;
            end
            S_EXEC: if (adv) begin
                state_d = last ? S_DONE : S_EXEC;
                beat_d  = last ? '0 : beat_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_ready_o = state_q == S_IDLE;
    assign busy_o        = state_q != S_IDLE;
    assign done_o        = state_q == S_DONE;
    assign wmem_o        = exec & str;
    assign rmem_o        = exec & ldr;
    assign wreg_o        = exec & (ldr | movr | movi | add | sub | mul | div);
    assign cond_en_o     = exec & (cmpr | cmpi);
    assign jmp_sel_o     = exec & (jmp | jeq | stl);
    assign vf_o          = exec & is_vec;
    assign jmp_f_o       = !exec ? 2'b00 : jmp ? 2'b01 : jeq ? 2'b10 : stl ? 2'b11 : 2'b00;
    assign alu_ins_o     = !exec ? 3'b000 : (sub | cmpr | cmpi) ? 3'b001 : mul ? 3'b010 :
                           div ? 3'b011 : (movr | movi) ? 3'b100 : 3'b000;
    assign extnd_sel_o   = !exec ? 2'b00 : (cmpi | movi) ? 2'b01 : (jmp | jeq | stl) ? 2'b10 :
                           is_mem ? 2'b11 : 2'b00;
    assign rmux_sel_o    = !(exec && is_vec) ? 2'b00 : is_mem ? 2'b01 : (add | sub) ? 2'b11 : 2'b10;
    assign lane_base_o   = (exec && is_vec) ? IW'(beat_q) << $clog2(LANES) : '0;
    assign lane_mask_o   = !exec ? '0 : is_vec ? '1 : LANES'(1);
endmodule

// File: doc/vector_issue_sequencer.md
VECTOR_ISSUE_SEQUENCER -- requirements
Module: vector_issue_sequencer

Interface
REQ-001 Parameter VLEN, default 16, vector length in elements; power of two, >= LANES.
REQ-002 Parameter LANES, default 4, elements processed per beat; power of two, divides VLEN.
REQ-003 Derived: BEATS = VLEN/LANES; IW = log2(VLEN).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk in 1: sole clock, rising edge.
REQ-006 rst_n in 1: async active-low reset.
REQ-007 instr_valid in 1: instruction offered.
REQ-008 instr_ready out 1: sequencer can accept.
REQ-009 op in 2, inst in 2, flagV in 1: instruction fields, sampled on accept.
REQ-010 mem_ready in 1: memory completes current beat.
REQ-011 wmem, rmem, wreg, cond_en, jmp_sel, vf out 1 each: control strobes.
REQ-012 jmp_f out 2, rmux_sel out 2, alu_ins out 3, extnd_sel out 2: control fields.
REQ-013 lane_base out IW: first element index of current beat.
REQ-014 lane_mask out LANES: active lanes of current beat.
REQ-015 busy out 1: instruction in flight; done out 1: one-cycle completion pulse.

Function
REQ-016 States: IDLE, EXEC, DONE; instr_ready = (state==IDLE).
REQ-017 Accept when instr_valid && instr_ready; op/inst/flagV registered; next state EXEC with beat = 0.
REQ-018 Decode: op 00: inst 00 JMP, 01 JEQ, 10 STL; op 01: 00 STR, 01 CMPR, 10 CMPI; op 10: 00 ADD, 01 SUB, 10 MUL, 11 DIV; op 11: 01 LDR, 10 MOVR, 11 MOVI; op01/inst11 and op11/inst00 are NOP.
REQ-019 Vector instruction = flagV=1 and one of STR, LDR, ADD, SUB, MUL, DIV; all other instructions are scalar regardless of flagV.
REQ-020 In EXEC: wmem=STR; rmem=LDR; wreg for LDR, MOVR, MOVI, ADD..DIV; cond_en for CMPR/CMPI; jmp_sel for JMP/JEQ/STL.
REQ-021 jmp_f: 01 JMP, 10 JEQ, 11 STL, else 00.
REQ-022 alu_ins: 000 ADD, 001 SUB/CMPR/CMPI, 010 MUL, 011 DIV, 100 MOVR/MOVI, else 000.
REQ-023 extnd_sel: 01 CMPI/MOVI, 10 JMP/JEQ/STL, 11 STR/LDR, else 00.
REQ-024 rmux_sel: scalar 00; vector STR/LDR 01; vector ADD/SUB 11; vector MUL/DIV 10.
REQ-025 vf = 1 in EXEC iff vector instruction.
REQ-026 Scalar: one EXEC beat, lane_base 0, lane_mask = 1 (lane 0 only).
REQ-027 Vector: BEATS beats, lane_base = beat*LANES, lane_mask all ones.
REQ-028 Beat advances on every EXEC cycle, except STR/LDR advance only when mem_ready=1; while stalled all outputs held, strobes remain asserted.
REQ-029 After the last beat advances, next state DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-030 All control strobes, fields, lane_base, lane_mask are 0 outside EXEC.
REQ-031 busy = 1 in EXEC and DONE.
REQ-032 NOP: one EXEC cycle with all strobes 0, then DONE.
REQ-033 instr_valid while not ready is ignored; instruction fields changing mid-operation have no effect.
REQ-034 Beat counter never exceeds BEATS-1; lane_base wraps never.

Reset
REQ-035 rst_n low forces immediately: state IDLE, beat 0, captured instruction cleared, all outputs 0 except instr_ready=1.
REQ-036 Reset mid-vector abandons the instruction; no done pulse is generated.
REQ-037 First accept is possible on the first rising edge after rst_n rises.

Verification
REQ-038 Scalar ADD (op10 inst00 flagV0) -> one EXEC cycle: wreg=1, alu_ins=000, rmux_sel=00, vf=0, lane_mask=0001; done next cycle.
REQ-039 Vector MULVE, VLEN16 LANES4 -> 4 EXEC cycles, lane_base 0,4,8,12, rmux_sel=10, vf=1, wreg=1; done on 5th cycle after accept.
REQ-040 Vector STR with mem_ready low 3 cycles on beat 1 -> lane_base holds 4, wmem=1, rmux_sel=01; total 7 EXEC cycles.
REQ-041 JEQ with flagV=1 -> scalar: jmp_sel=1, jmp_f=10, extnd_sel=10, vf=0, single beat.
REQ-042 rst_n pulsed low during beat 2 of vector ADD -> outputs 0 asynchronously, instr_ready=1, no done pulse.
REQ-043 Back-to-back instr_valid held high -> accepts every 3 cycles for scalar, instr_ready low while busy.
